keypad_scanner: RTL and testbench

- Upstream stage of the scan-clock cutter in the keypad input path.
- Drives a 4x4 matrix keypad one column at a time, paced by `clk_cut`.
- Debounces and encodes a pressed key to a 4-bit hex code.
- Emits the `stop_flag` pulse that freezes scanning and starts the cutter's display/hold window.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scanner_row_synchronizer.sv | 30 +++
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEY_MAP is indexed [row][col]; row 3 carries '*' as E and '#' as F.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        REPORT,
        WAIT_RELEASE
    } scan_state_t;

    // Packed [row][col][code]: each 16-bit row group is {col3, col2, col1, col0}.
    localparam logic [NUM_ROWS-1:0][NUM_COLS-1:0][3:0] KEY_MAP =
        64'hDF0E_C987_B654_A321;

    function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_row_synchronizer.sv
// Multi-stage synchronizer for the asynchronous active-low keypad rows.
// Every stage resets to 1 so that reset looks like "no key pressed".
module row_synchronizer #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '1;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad front end: debounces on clk_cut ticks, reports one
// hex code per press with a stop_flag pulse, then waits for a full release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int STABLE_SCANS   = 2,
    parameter int RELEASE_CYCLES = 27000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_cut,
    input  logic                enable_input,
    input  logic [NUM_ROWS-1:0] rows_n,
    output logic [NUM_COLS-1:0] cols_n,
    output logic                stop_flag,
    output logic [3:0]          key_code,
    output logic                key_valid
);

    localparam int CNT_W = $clog2(STABLE_SCANS + 1);
    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CONFIRM_TARGET = CNT_W'(STABLE_SCANS);
    localparam logic [REL_W-1:0] RELEASE_LAST   = REL_W'(RELEASE_CYCLES - 1);

    scan_state_t       state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [CNT_W-1:0]  confirm_cnt_q, confirm_cnt_d;
    logic [CNT_W-1:0]  confirm_inc;
    logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              clk_prev;
    logic              tick;
    logic [NUM_ROWS-1:0] rows_s;
    logic [1:0]        row_sel;
    logic              any_low;

    row_synchronizer #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (NUM_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows_n),
        .q     (rows_s)
    );

    // clk_prev resets high so a clk_cut already high at reset release is not a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_cut;
        end
    end

    assign tick        = clk_cut & ~clk_prev;
    assign row_sel     = first_low_row(rows_s);
    assign any_low     = (rows_s != '1);
    assign confirm_inc = confirm_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SCAN;
            col_idx_q     <= 2'd0;
            row_q         <= 2'd0;
            col_q         <= 2'd0;
            confirm_cnt_q <= '0;
            rel_cnt_q     <= '0;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            row_q         <= row_d;
            col_q         <= col_d;
            confirm_cnt_q <= confirm_cnt_d;
            rel_cnt_q     <= rel_cnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        row_d         = row_q;
        col_d         = col_q;
        confirm_cnt_d = confirm_cnt_q;
        rel_cnt_d     = rel_cnt_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (any_low && enable_input) begin
                        row_d         = row_sel;
                        col_d         = col_idx_q;
                        confirm_cnt_d = CNT_W'(1);
                        state_d       = (STABLE_SCANS == 1) ? REPORT : CONFIRM;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            CONFIRM: begin
                if (tick) begin
                    if (!rows_s[row_q]) begin
                        confirm_cnt_d = confirm_inc;
                        if (confirm_inc == CONFIRM_TARGET) begin
                            state_d = REPORT;
                        end
                    end else begin
                        state_d       = SCAN;
                        col_idx_d     = col_idx_q + 2'd1;
                        confirm_cnt_d = '0;
                    end
                end
            end
            REPORT: begin
                state_d       = WAIT_RELEASE;
                confirm_cnt_d = '0;
                rel_cnt_d     = '0;
            end
            WAIT_RELEASE: begin
                if (any_low) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == RELEASE_LAST) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    rel_cnt_d = '0;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        // Latch the code on entry to REPORT so it is valid alongside stop_flag.
        if (state_d == REPORT && state_q != REPORT) begin
            key_code_d  = KEY_MAP[row_d][col_d];
            key_valid_d = 1'b1;
        end
    end

    assign cols_n    = ~(4'b0001 << col_idx_q);
    assign stop_flag = (state_q == REPORT);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model answers the column drive,
// expected reports are queued by the stimulus and checked on every stop_flag.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic       clk_cut;
    logic       enable_input;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic       stop_flag;
    logic [3:0] key_code;
    logic       key_valid;

    logic [15:0] pressed;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] cols;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   reports_seen = 0;
    logic prev_stop    = 1'b0;

    keypad_scanner #(
        .STABLE_SCANS   (2),
        .RELEASE_CYCLES (8),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_cut      (clk_cut),
        .enable_input (enable_input),
        .rows_n       (rows_n),
        .cols_n       (cols_n),
        .stop_flag    (stop_flag),
        .key_code     (key_code),
        .key_valid    (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // clk_cut runs at 1/16 of clk, changing just after a clk rising edge.
    initial begin
        clk_cut = 1'b0;
        forever begin
            repeat (8) @(posedge clk);
            #1 clk_cut = ~clk_cut;
        end
    end

    // Key at bit r*4+c shorts row r to column c whenever that column is driven low.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols_n[c]) begin
                    rows_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input logic expect_report,
                                 input logic [3:0] code, input logic [3:0] cols);
        if (expect_report) begin
            exp_q.push_back('{code: code, cols: cols});
        end
        @(negedge clk);
        pressed = keys;
    endtask

    task automatic wait_tick();
        @(posedge clk_cut);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_reports(input int target, input string name);
        for (int i = 0; i < 400 && reports_seen < target; i++) begin
            @(negedge clk);
        end
        checkOutput(name, reports_seen, target);
    endtask

    task automatic wait_cols(input logic [3:0] value, input string name);
        for (int i = 0; i < 400 && cols_n !== value; i++) begin
            @(negedge clk);
        end
        checkOutput(name, cols_n, value);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // Monitor: every stop_flag pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && stop_flag) begin
            if (prev_stop) begin
                checkOutput("stop_flag_width", 32'(prev_stop), 32'(1'b0));
            end else if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_report: got code %0h, expected no report", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("report_key_code", key_code, mon_exp.code);
                checkOutput("report_key_valid", key_valid, 1);
                checkOutput("report_cols_n", cols_n, mon_exp.cols);
            end
            if (!prev_stop) begin
                reports_seen++;
            end
        end
        prev_stop = stop_flag;
    end

    initial begin
        logic [3:0] c0;
        reset        = 1'b0;
        enable_input = 1'b1;
        pressed      = 16'h0;

        repeat (40) @(negedge clk);
        checkOutput("reset_cols_n", cols_n, 4'b1110);
        checkOutput("reset_stop_flag", stop_flag, 0);
        checkOutput("reset_key_code", key_code, 4'h0);
        checkOutput("reset_key_valid", key_valid, 0);
        @(negedge clk_cut);
        @(negedge clk);
        reset = 1'b1;

        wait_tick(); checkOutput("scan_step1", cols_n, 4'b1101);
        wait_tick(); checkOutput("scan_step2", cols_n, 4'b1011);
        wait_tick(); checkOutput("scan_step3", cols_n, 4'b0111);
        wait_tick(); checkOutput("scan_step4", cols_n, 4'b1110);

        $display("[TB] key 5");
        applyStimulus(16'h1 << 5, 1'b1, 4'h5, 4'b1101);
        wait_reports(1, "key5_reported");
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_cols(4'b1011, "key5_resume");

        $display("[TB] bounce");
        wait_cols(4'b1101, "bounce_reach_col1");
        applyStimulus(16'h1 << 5, 1'b0, 4'h0, 4'h0);
        wait_tick();
        checkOutput("bounce_hold_col", cols_n, 4'b1101);
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_tick();
        checkOutput("bounce_advance", cols_n, 4'b1011);
        checkOutput("bounce_no_report", reports_seen, 1);
        checkOutput("key_code_persist", key_code, 4'h5);

        $display("[TB] hold and re-press");
        applyStimulus(16'h1 << 13, 1'b1, 4'h0, 4'b1101);
        wait_reports(2, "key0_reported");
        repeat (100) @(negedge clk);
        checkOutput("hold_cols_frozen", cols_n, 4'b1101);
        checkOutput("hold_single_report", reports_seen, 2);
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_cols(4'b1011, "hold_resume");
        applyStimulus(16'h1 << 13, 1'b1, 4'h0, 4'b1101);
        wait_reports(3, "key0_repress");
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_cols(4'b1011, "repress_resume");

        $display("[TB] row priority");
        applyStimulus((16'h1 << 3) | (16'h1 << 11), 1'b1, 4'hA, 4'b0111);
        wait_reports(4, "keyA_reported");
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_cols(4'b1110, "keyA_resume");
        applyStimulus(16'h1 << 12, 1'b1, 4'hE, 4'b1110);
        wait_reports(5, "keyE_reported");
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_cols(4'b1101, "keyE_resume");

        $display("[TB] enable gating");
        @(negedge clk);
        enable_input = 1'b0;
        applyStimulus(16'h1 << 10, 1'b0, 4'h0, 4'h0);
        wait_tick();
        for (int i = 0; i < 6; i++) begin
            c0 = cols_n;
            wait_tick();
            checkOutput("disabled_scan_step", cols_n, rotl(c0));
        end
        checkOutput("disabled_no_report", reports_seen, 5);
        exp_q.push_back('{code: 4'h9, cols: 4'b1011});
        @(negedge clk);
        enable_input = 1'b1;
        wait_reports(6, "key9_reported");
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        wait_cols(4'b0111, "key9_resume");

        $display("[TB] reset during confirm");
        wait_cols(4'b1011, "confirm_reach_col2");
        applyStimulus(16'h1 << 2, 1'b0, 4'h0, 4'h0);
        wait_tick();
        checkOutput("confirm_hold_col", cols_n, 4'b1011);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_cols_n", cols_n, 4'b1110);
        checkOutput("midreset_stop_flag", stop_flag, 0);
        checkOutput("midreset_key_code", key_code, 4'h0);
        checkOutput("midreset_key_valid", key_valid, 0);
        applyStimulus(16'h0, 1'b0, 4'h0, 4'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("midreset_no_report", reports_seen, 6);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
